// File: rtl/div_sequencer_pkg.sv
// Shared instruction defines for the iterative divider: FSM encodings,
// iteration count and the MIPS DIV/DIVU funct codes.
package div_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BYZERO = 2'b01,
        ST_ON     = 2'b10,
        ST_DONE   = 2'b11
    } div_state_e;

    localparam int DIV_ITER = 32;
    localparam int CNT_W    = $clog2(DIV_ITER);

    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

endpackage

// File: rtl/div_sequencer_step.sv
// One restoring-division step: shift the {remainder, quotient} register left,
// trial-subtract the divisor from the upper part and keep the result when it
// does not go negative, recording a 1 in the new quotient LSB.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0]   rq_i,
    input  logic [DATA_W-1:0]   divisor_i,
    output logic [2*DATA_W:0]   rq_o
);

    // Upper part after the shift, one bit wider than the remainder field so
    // the subtraction borrow is visible in the MSB.
    logic [DATA_W+1:0] trial;

    // Trial subtraction and restore/keep selection.
    always_comb begin
        trial = rq_i[2*DATA_W:DATA_W-1] - {2'b00, divisor_i};
        if (!trial[DATA_W+1]) begin
            rq_o = {trial[DATA_W:0], rq_i[DATA_W-2:0], 1'b1};
        end else begin
            rq_o = {rq_i[2*DATA_W-1:DATA_W-1], rq_i[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer. Latches operands from the E stage, runs 32
// restoring steps (one per cycle) while stalling the front of the pipeline,
// then applies the sign fix-up and presents {remainder, quotient} for HI/LO.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    input  logic                  annul_i,
    output logic                  stall_o,
    output logic                  ready_o,
    output logic [2*DATA_W-1:0]   result_o
);

    div_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [2*DATA_W:0]      rq_q;
    logic [DATA_W-1:0]      divisor_q;
    logic                   neg_quot_q;
    logic                   neg_rem_q;
    logic [2*DATA_W-1:0]    result_q;
    logic [2*DATA_W:0]      step_out;
    logic                   accept;
    logic                   last_step;

    // Magnitude of a two's complement value; the most negative value maps to
    // itself, which read as unsigned is its correct magnitude.
    function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
        logic signed [DATA_W-1:0] n;
        n = -v;
        return v[DATA_W-1] ? DATA_W'(n) : DATA_W'(v);
    endfunction

    // Conditional two's complement negation.
    function automatic logic [DATA_W-1:0] neg_if(input logic signed [DATA_W-1:0] v,
                                                 input logic neg);
        logic signed [DATA_W-1:0] n;
        n = -v;
        return neg ? DATA_W'(n) : DATA_W'(v);
    endfunction

    // Sign fix-up: quotient negative when operand signs differ, remainder
    // follows the dividend. 0x80000000 / -1 naturally yields 0x80000000.
    function automatic logic [2*DATA_W-1:0] fix_sign(input logic [2*DATA_W:0] rq,
                                                     input logic nq,
                                                     input logic nr);
        return {neg_if(rq[2*DATA_W-1:DATA_W], nr), neg_if(rq[DATA_W-1:0], nq)};
    endfunction

    assign accept    = start_i & ~annul_i;
    assign last_step = (cnt_q == CNT_W'(DIV_ITER - 1));

    div_step #(.DATA_W(DATA_W)) u_step (
        .rq_i      (rq_q),
        .divisor_i (divisor_q),
        .rq_o      (step_out)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; annul aborts any busy state, DONE always returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (b_i == '0) ? ST_BYZERO : ST_ON;
                end
            end
            ST_BYZERO: state_d = annul_i ? ST_IDLE : ST_DONE;
            ST_ON: begin
                if (annul_i) begin
                    state_d = ST_IDLE;
                end else if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs: ready while in DONE; stall while a DIV sits in E without a result.
    always_comb begin
        ready_o  = (state_q == ST_DONE);
        stall_o  = start_i & ~ready_o & ~annul_i;
        result_o = result_q;
    end

    // Operand latch, iteration register and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            rq_q       <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (accept) begin
                cnt_q      <= '0;
                rq_q       <= {{(DATA_W+1){1'b0}}, signed_i ? abs_val(a_i) : a_i};
                divisor_q  <= signed_i ? abs_val(b_i) : b_i;
                neg_quot_q <= signed_i & (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
                neg_rem_q  <= signed_i & a_i[DATA_W-1];
            end
        end else if (state_q == ST_ON && !annul_i) begin
            rq_q  <= step_out;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Result register: written only when entering DONE, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else if (state_d == ST_DONE) begin
            if (state_q == ST_BYZERO) begin
                result_q <= '0;
            end else if (state_q == ST_ON) begin
                result_q <= fix_sign(step_out, neg_quot_q, neg_rem_q);
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, signed/unsigned results,
// divide-by-zero, overflow, annul, reset, start drop and back-to-back.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        annul_i;
    logic        stall_o;
    logic        ready_o;
    logic [63:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;

    div_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .signed_i (signed_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .annul_i  (annul_i),
        .stall_o  (stall_o),
        .ready_o  (ready_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    // Generic division run starting in the current cycle (called just after a rising edge).
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_res, input int exp_cyc, input string name);
        logic exp_rdy, exp_stall;
        signed_i = sgn; a_i = a; b_i = b; annul_i = 1'b0; start_i = 1'b1;
        #1;
        for (int c = 0; c <= exp_cyc + 1; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            exp_rdy   = (c == exp_cyc);
            exp_stall = (c < exp_cyc);
            n_checks++;
            if (ready_o !== exp_rdy) begin
                n_fail++;
                $display("FAIL %s ready cycle %0d: got %b want %b", name, c, ready_o, exp_rdy);
            end
            n_checks++;
            if (stall_o !== exp_stall) begin
                n_fail++;
                $display("FAIL %s stall cycle %0d: got %b want %b", name, c, stall_o, exp_stall);
            end
            if (c == exp_cyc) begin
                n_checks++;
                if (result_o !== exp_res) begin
                    n_fail++;
                    $display("FAIL %s result: got %h want %h", name, result_o, exp_res);
                end
                start_i = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; a_i = '0; b_i = '0; annul_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset ready: got %b want 0", ready_o); end
        n_checks++;
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset stall: got %b want 0", stall_o); end
        n_checks++;
        if (result_o !== 64'h0) begin n_fail++; $display("FAIL reset result: got %h want 0", result_o); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, "divu_100_7");
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "div_m7_2");
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 33, "div_7_m2");
    endtask

    task automatic test_div_zero();
        run_div(1'b1, 32'd5, 32'd0, 64'h0, 2, "div_5_0");
    endtask

    task automatic test_overflow();
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33, "div_ovf");
    endtask

    // Annul mid-operation; the previous (overflow) result must survive.
    task automatic test_annul();
        signed_i = 1'b0; a_i = 32'd9; b_i = 32'd3; annul_i = 1'b0; start_i = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
        end
        annul_i = 1'b1;
        #1;
        n_checks++;
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL annul stall: got %b want 0", stall_o); end
        @(posedge clk); #1;
        annul_i = 1'b0; start_i = 1'b0;
        for (int c = 11; c < 50; c++) begin
            n_checks++;
            if (ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL annul ready cycle %0d: got %b want 0", c, ready_o);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (result_o !== {32'h0, 32'h80000000}) begin
            n_fail++;
            $display("FAIL annul result held: got %h want %h", result_o, {32'h0, 32'h80000000});
        end
    endtask

    // Asynchronous reset in the middle of a division, then a clean restart.
    task automatic test_reset_mid_op();
        signed_i = 1'b0; a_i = 32'h12345678; b_i = 32'd3; annul_i = 1'b0; start_i = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1; start_i = 1'b0;
        #1;
        n_checks++;
        if (ready_o !== 1'b0) begin n_fail++; $display("FAIL midrst ready: got %b want 0", ready_o); end
        n_checks++;
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL midrst stall: got %b want 0", stall_o); end
        n_checks++;
        if (result_o !== 64'h0) begin n_fail++; $display("FAIL midrst result: got %h want 0", result_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst ready after release %0d: got %b want 0", c, ready_o);
            end
        end
        run_div(1'b0, 32'd1001, 32'd10, {32'd1, 32'd100}, 33, "after_rst");
    endtask

    // start_i drops while ON; division still completes.
    task automatic test_start_drop();
        signed_i = 1'b0; a_i = 32'hDEADBEEF; b_i = 32'h10; annul_i = 1'b0; start_i = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk); #1;
            if (c == 5) start_i = 1'b0;
            n_checks++;
            if (ready_o !== (c == 33)) begin
                n_fail++;
                $display("FAIL drop ready cycle %0d: got %b want %b", c, ready_o, (c == 33));
            end
            if (c == 33) begin
                n_checks++;
                if (result_o !== {32'hF, 32'h0DEADBEE}) begin
                    n_fail++;
                    $display("FAIL drop result: got %h want %h", result_o, {32'hF, 32'h0DEADBEE});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_rdy, exp_stall;
        signed_i = 1'b0; a_i = 32'hFFFFFFFF; b_i = 32'd1; annul_i = 1'b0; start_i = 1'b1;
        for (int c = 1; c <= 68; c++) begin
            @(posedge clk); #1;
            exp_rdy   = (c == 33) || (c == 67);
            exp_stall = (c < 67) && (c != 33);
            n_checks++;
            if (ready_o !== exp_rdy) begin
                n_fail++;
                $display("FAIL b2b ready cycle %0d: got %b want %b", c, ready_o, exp_rdy);
            end
            n_checks++;
            if (stall_o !== exp_stall) begin
                n_fail++;
                $display("FAIL b2b stall cycle %0d: got %b want %b", c, stall_o, exp_stall);
            end
            if (c == 33) begin
                n_checks++;
                if (result_o !== {32'h0, 32'hFFFFFFFF}) begin
                    n_fail++;
                    $display("FAIL b2b result1: got %h want %h", result_o, {32'h0, 32'hFFFFFFFF});
                end
                a_i = 32'd10; b_i = 32'd3;
            end
            if (c == 67) begin
                n_checks++;
                if (result_o !== {32'd1, 32'd3}) begin
                    n_fail++;
                    $display("FAIL b2b result2: got %h want %h", result_o, {32'd1, 32'd3});
                end
                start_i = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_overflow();
        test_annul();
        test_reset_mid_op();
        test_start_drop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
